// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: line synchronizer, 8N1/8E1 deframer, show-ahead rx FIFO, idle timeout; optional parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rx_i,
    input  logic                       en_i,
    input  logic [15:0]                baud_div_i,
    input  logic                       parity_en_i,
    input  logic [7:0]                 timeout_i,
    input  logic                       fifo_clr_i,
    input  logic                       rd_i,
    output logic [7:0]                 rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       frame_err_o,
    output logic                       parity_err_o,
    output logic                       overrun_o,
    output logic                       timeout_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic           rx_s1, rx_s2, rx_d;
    logic           rx, rx_fall;
    logic [15:0]    div, half, last;

    state_t         state_q, state_d;
    logic [15:0]    ccnt_q, ccnt_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           push_q, push_d;
    logic           ferr_q, ferr_d;
    logic           perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
    logic           par_q, par_d;
`else
    logic           unused_parity_en;
    assign unused_parity_en = parity_en_i;
`endif

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    level_q;
    logic           empty, full, do_push, do_pop, ovr_d, ovr_q;

    logic [15:0]    tclk_q;
    logic [7:0]     tcnt_q;
    logic           to_q, to_cond, to_kick;

    // Two-flop synchronizer plus a delay flop for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx      = rx_s2;
    assign rx_fall = rx_d & ~rx_s2;

    // Effective divisor is clamped to 4; start bit is checked half a bit in, later bits a full bit apart
    always_comb begin
        div  = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
        half = {1'b0, div[15:1]};
        last = div - 16'd1;
    end

    // Deframer next-state logic
    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (!en_i) begin
            state_d = IDLE;
            ccnt_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fall) begin
                        state_d = START;
                        ccnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end
                end
                START: begin
                    if (ccnt_q == half) begin
                        ccnt_d = '0;
                        bcnt_d = '0;
                        state_d = rx ? IDLE : DATA;
                    end else begin
                        ccnt_d = ccnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (ccnt_q == last) begin
                        ccnt_d  = '0;
                        shreg_d = {rx, shreg_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = parity_en_i ? PARITY : STOP;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        ccnt_d = ccnt_q + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (ccnt_q == last) begin
                        ccnt_d  = '0;
                        par_d   = ^{shreg_q, rx};
                        state_d = STOP;
                    end else begin
                        ccnt_d = ccnt_q + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (ccnt_q == last) begin
                        ccnt_d  = '0;
                        state_d = IDLE;
                        if (!rx) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        else if (par_q) perr_d = 1'b1;
`endif
                        else push_d = 1'b1;
                    end else begin
                        ccnt_d = ccnt_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Deframer state, counters and the registered push/error pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ccnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle; clear wins over both
    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = rd_i & ~empty & ~fifo_clr_i;
    assign do_push = push_q & (~full | do_pop) & ~fifo_clr_i;
    assign ovr_d   = push_q & full & ~do_pop & ~fifo_clr_i;

    // FIFO storage, pointers, level and the overrun pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            if (fifo_clr_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
            end else begin
                if (do_push) begin
                    mem[wptr_q] <= shreg_q;
                    wptr_q      <= wptr_q + AW'(1);
                end
                if (do_pop) rptr_q <= rptr_q + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   level_q <= level_q + (AW+1)'(1);
                    2'b01:   level_q <= level_q - (AW+1)'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    assign to_cond = ~empty & (state_q == IDLE) & (timeout_i != 8'd0);
    assign to_kick = do_push | do_pop | fifo_clr_i;

    // Idle timeout: counts whole bit periods while data waits in an idle receiver
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tclk_q <= '0;
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            if (to_kick) begin
                tclk_q <= '0;
                tcnt_q <= '0;
            end else if (to_cond) begin
                if (tclk_q == last) begin
                    tclk_q <= '0;
                    if (tcnt_q != 8'hff) tcnt_q <= tcnt_q + 8'd1;
                end else begin
                    tclk_q <= tclk_q + 16'd1;
                end
            end
            if (to_kick || empty) to_q <= 1'b0;
            else if (to_cond && (tcnt_q == timeout_i)) to_q <= 1'b1;
        end
    end

    assign rd_data_o    = mem[rptr_q];
    assign level_o      = level_q;
    assign empty_o      = empty;
    assign full_o       = full;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;
    assign timeout_o    = to_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage of the UART. Consumes the asynchronous `rx_i` line that the APB UART slave routes into the UART core. Oversamples with a programmable clocks-per-bit divisor and deframes 8N1 (optionally 8E1) characters. Buffers received bytes in a show-ahead FIFO whose status drives the core's rx interrupts (`intr_rx`, `intr_rx_full`, `intr_rx_empty`, `intr_rx_timeout`).

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial line; asynchronous to `clk_i`; idle high.
- `en_i` in 1: receiver enable.
- `baud_div_i` in 16: clocks per bit; values <4 behave as 4.
- `parity_en_i` in 1: even-parity bit expected after data (macro-dependent).
- `timeout_i` in 8: idle timeout in bit periods; 0 disables.
- `fifo_clr_i` in 1: synchronous FIFO flush.
- `rd_i` in 1: pop head entry.
- `rd_data_o` out 8: FIFO head (valid when `!empty_o`).
- `level_o` out $clog2(DEPTH)+1: entries held.
- `empty_o`, `full_o` out 1: FIFO status.
- `frame_err_o`, `parity_err_o`, `overrun_o` out 1: single-cycle error pulses.
- `timeout_o` out 1: level-sensitive rx timeout.

## Operation
- `rx_i` passes a 2-FF synchronizer (reset to 1). "rx" below means the synced value. A falling edge means previous synced = 1 and current = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. Clock counter `ccnt` (16b), bit counter `bcnt` (3b).
- IDLE: when `en_i` is high and rx shows a falling edge, go to START with `ccnt` = 0.
- START: at `ccnt` == div/2 (div = effective divisor), sample rx.
  - 1: glitch; return to IDLE, nothing reported.
  - 0: go to DATA with `ccnt` = 0, `bcnt` = 0.
- DATA: sample when `ccnt` == div−1 (mid-bit), then restart `ccnt`. Shift LSB first. After the 8th sample, go to PARITY if parity is active, else to STOP.
- PARITY: sample at mid-bit. Error if XOR(data, parity bit) ≠ 0.
- STOP: sample at mid-bit, then return to IDLE on the next cycle.
  - stop = 0: pulse `frame_err_o`; discard the byte.
  - stop = 1 with parity error: pulse `parity_err_o`; discard the byte.
  - Otherwise push the byte.
- A new frame can start immediately after STOP; it needs a fresh falling edge, so a held break produces one frame error only.
- Push on full FIFO: byte dropped, `overrun_o` pulses, contents unchanged. Exception: when `rd_i` is asserted in the same cycle, pop and push both occur and `level_o` stays at DEPTH.
- `rd_i` while empty is ignored.
- Push and pop in the same non-full, non-empty cycle leave `level_o` unchanged.
- `fifo_clr_i` overrides push and pop. `level_o` goes to 0 and pointers reset. A push coincident with clear is lost, with no overrun pulse.
- `en_i` low forces IDLE and discards a partial frame. The FIFO is kept.
- `baud_div_i` is sampled continuously. Changing it mid-frame is unsupported; the only guarantee is that the FSM returns to IDLE within one frame.
- Timeout counter:
  - Counts bit periods while the FIFO is non-empty, the FSM is in IDLE, and `timeout_i` ≠ 0.
  - Cleared by push, pop, or clear.
  - `timeout_o` sets when the count reaches `timeout_i`, and holds until push, pop, clear, or the FIFO goes empty.

## Timing
- Reset values:
  - FSM in IDLE, all counters 0, synchronizer = 1.
  - `rd_data_o` = 0, `level_o` = 0, `empty_o` = 1, `full_o` = 0.
  - All pulses 0, `timeout_o` = 0.
- Line-to-FSM latency is 2 cycles of synchronizer plus 1 cycle of edge detection.
- Push occurs the cycle after the STOP sample. `level_o`, `empty_o`, `full_o`, and `rd_data_o` update on the following edge.
- With div = 16, 8N1: byte visible about 3 + 8 + 16·9 = 155 cycles after the start-bit falling edge on `rx_i`.
- Error pulses are registered and high for exactly 1 cycle, aligned with the would-be push cycle.
- Pop: `rd_data_o` shows the next entry one cycle after `rd_i`.
- Reset asserted mid-frame aborts immediately. After release the block sits in IDLE and waits for a fresh falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and the `parity_err_o` logic are compiled in, and `parity_en_i` selects 8E1.
- Undefined: `parity_en_i` is ignored, frames are always 8N1, and `parity_err_o` is tied to 0.

## Test plan
- div = 16, send 0xA5 8N1: `level_o` = 1, `rd_data_o` = 0xA5 within 160 cycles; `rd_i` → `empty_o` = 1.
- div = 16, 4-cycle low glitch on `rx_i`: FSM back to IDLE; no push and no error pulse.
- Send 0x3C with stop bit = 0: one `frame_err_o` pulse; `level_o` stays 0. Then send 0x11: `rd_data_o` = 0x11.
- DEPTH = 8, send 9 bytes 0x00–0x08 without reads:
  - `full_o` = 1; `overrun_o` pulses once.
  - Read-out gives 0x00–0x07.
  - Repeat with `rd_i` coincident with the 9th push: 0x08 is retained.
- `timeout_i` = 4, div = 16, one byte received: `timeout_o` rises after 64 idle cycles; `rd_i` clears it. With `timeout_i` = 0 it never asserts.
- With `UART_RX_PARITY_EN` and `parity_en_i` = 1: 0x03 with parity 0 → pushed; 0x03 with parity 1 → `parity_err_o` pulse, no push. Reset asserted at data bit 4 → all outputs at reset values.
